spi_pixel_receiver: RTL
=======================

SPI_PIXEL_RECEIVER -- requirements
Module: spi_pixel_receiver

Interface
REQ-001 Parameter WIDTH, 64, panel columns.
REQ-002 Parameter HEIGHT, 32, panel rows.
REQ-003 Parameter PIXEL_BITS, 16, bits per pixel word, MSB first on the wire.
REQ-004 Parameter IDLE_TIMEOUT, 1024, clk cycles without an spi_clk rising edge before resync.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  system clock; all state on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 spi_clk  input  1  SPI clock from host, asynchronous to clk; mode 0.
REQ-009 spi_mosi  input  1  SPI data from host, asynchronous to clk.
REQ-010 pixel_data  output  PIXEL_BITS  completed pixel word.
REQ-011 pixel_addr  output  clog2(WIDTH*HEIGHT)  linear address of pixel_data, row-major (y*WIDTH+x).
REQ-012 pixel_write  output  1  one-cycle write strobe into the framebuffer.
REQ-013 write_buffer  output  1  framebuffer half being written; the display side reads the other half.
REQ-014 frame_complete  output  1  one-cycle pulse when the last pixel of a frame is written.

Function
REQ-015 spi_clk and spi_mosi SHALL each pass through a two-flop synchronizer on clk before any use.
REQ-016 A rising edge SHALL be detected when the synchronized spi_clk is 1 and its previous value was 0; mosi SHALL be sampled from the same synchronizer stage as the clock.
REQ-017 Each detected edge SHALL shift the sampled bit into a PIXEL_BITS shift register, MSB first, and increment a bit counter.
REQ-018 The cycle after the edge carrying bit PIXEL_BITS-1: pixel_write=1, pixel_data=assembled word, pixel_addr=current pixel counter; bit counter returns to 0.
REQ-019 pixel_data and pixel_addr SHALL hold their values until the next pixel_write.
REQ-020 The pixel counter SHALL increment after each write and wrap from WIDTH*HEIGHT-1 to 0.
REQ-021 The write of address WIDTH*HEIGHT-1 SHALL assert frame_complete in the same cycle as pixel_write, and toggle write_buffer on the following cycle.
REQ-022 The write of address 0 of the next frame SHALL therefore target the new write_buffer value.
REQ-023 Input timing: spi_clk high and low phases SHALL each be at least 3 clk periods; slower rates are always valid.
REQ-024 An edge arriving in the cycle of pixel_write SHALL be accepted as bit 15 of the next word; no bit is lost.

Reset
REQ-025 Reset SHALL clear pixel_data, pixel_addr, pixel_write, write_buffer, frame_complete, shift register, bit counter, pixel counter, idle counter and synchronizer flops to 0.
REQ-026 Reset asserted mid-word or mid-frame SHALL discard the partial word/frame with no write and no buffer toggle.

Configuration
REQ-027 With macro SPI_IDLE_RESYNC_EN defined: an idle counter counts clk cycles without an spi_clk rising edge; on reaching IDLE_TIMEOUT, the bit counter and pixel counter SHALL reset to 0, with write_buffer unchanged and no pixel_write or frame_complete.
REQ-028 Any detected edge SHALL clear the idle counter; the counter SHALL saturate at IDLE_TIMEOUT.
REQ-029 Without SPI_IDLE_RESYNC_EN: no idle counter exists; bit and pixel counters advance only by edges and reset.

Verification
REQ-030 Shift 0xF00F, 16 edges -> one pixel_write, pixel_data=0xF00F, pixel_addr=0.
REQ-031 2048 words 0x0000..0x07FF -> addresses 0..2047 in order with data=address; frame_complete once with address 2047; write_buffer 0->1 next cycle.
REQ-032 Two full frames -> write_buffer 0->1->0; pixel_addr wraps 2047->0 with no extra write.
REQ-033 Assert reset after 7 bits of a word, then send 0x1234 -> pixel_data=0x1234, pixel_addr=0, write_buffer=0.
REQ-034 SPI_IDLE_RESYNC_EN: send 5 bits, idle 1100 cycles, send 0xABCD -> pixel_data=0xABCD at pixel_addr=0; without macro, the word is misaligned (first 5 stale bits as MSBs).
REQ-035 Minimum-rate spi_clk (3 clk high / 3 low) for 64 words -> 64 writes, no bits dropped.

Source files
------------

// File: rtl/spi_pixel_receiver.sv
// ----------------------------------------------------------------------------
// spi_pixel_receiver
//
// Receives pixel words from an SPI host (mode 0, MSB first) and writes them
// into one half of a double-buffered framebuffer. Addresses advance
// row-major through the panel. After the last pixel of a frame, the
// half being written flips, so the display side can read the finished frame.
//
// Optional feature (macro SPI_IDLE_RESYNC_EN): if spi_clk has no rising edge
// for IDLE_TIMEOUT clk cycles, the bit and pixel counters return to 0. The
// host can then recover word/frame alignment by pausing. When the macro is
// not defined, no idle counter exists.
//
// Ports
//   clk            in   system clock, all state on its rising edge
//   reset          in   asynchronous, active-high reset
//   spi_clk        in   SPI clock from host (asynchronous to clk)
//   spi_mosi       in   SPI data from host (asynchronous to clk)
//   pixel_data     out  completed pixel word, held until the next write
//   pixel_addr     out  linear address y*WIDTH+x of pixel_data, held
//   pixel_write    out  one-cycle framebuffer write strobe
//   write_buffer   out  framebuffer half currently being written
//   frame_complete out  one-cycle pulse with the write of the last pixel
// ----------------------------------------------------------------------------
module spi_pixel_receiver #(
  parameter int WIDTH        = 64,
  parameter int HEIGHT       = 32,
  parameter int PIXEL_BITS   = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             spi_clk,
  input  logic                             spi_mosi,
  output logic [PIXEL_BITS-1:0]            pixel_data,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]  pixel_addr,
  output logic                             pixel_write,
  output logic                             write_buffer,
  output logic                             frame_complete
);

  localparam int NUM_PIXELS = WIDTH * HEIGHT;
  localparam int ADDR_W     = $clog2(NUM_PIXELS);
  localparam int BIT_W      = $clog2(PIXEL_BITS);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(PIXEL_BITS - 1);

  // Two-flop synchronizers. Index [1] is the stable stage. Clock and data
  // come from the same stage, so they stay aligned to each other.
  logic [1:0] spi_clk_sync;
  logic [1:0] spi_mosi_sync;
  logic       spi_clk_prev;

  // The partial word only needs PIXEL_BITS-1 stored bits. The last bit is
  // taken directly from the synchronizer when the word completes.
  logic [PIXEL_BITS-2:0] shift_reg;
  logic [BIT_W-1:0]      bit_cnt;
  logic [ADDR_W-1:0]     pix_cnt;

  logic                  spi_rise;
  logic                  bit_in;
  logic [PIXEL_BITS-1:0] assembled;
  logic                  resync;

  assign spi_rise  = spi_clk_sync[1] & ~spi_clk_prev;
  assign bit_in    = spi_mosi_sync[1];
  assign assembled = {shift_reg, bit_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spi_clk_sync  <= '0;
      spi_mosi_sync <= '0;
      spi_clk_prev  <= 1'b0;
    end else begin
      // NOTE: all sequential state uses non-blocking assignments. Each flop
      // then samples the value from before the edge, which makes a shift
      // chain like this behave as a real synchronizer.
      spi_clk_sync  <= {spi_clk_sync[0], spi_clk};
      spi_mosi_sync <= {spi_mosi_sync[0], spi_mosi};
      spi_clk_prev  <= spi_clk_sync[1];
    end
  end

`ifdef SPI_IDLE_RESYNC_EN
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_PRE = IDLE_W'(IDLE_TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_cnt;

  // Saturating count of clk cycles since the last spi_clk rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (spi_rise) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Fires once, in the cycle where the count reaches IDLE_TIMEOUT.
  assign resync = !spi_rise && (idle_cnt == IDLE_PRE);
`else
  assign resync = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg      <= '0;
      bit_cnt        <= '0;
      pix_cnt        <= '0;
      pixel_data     <= '0;
      pixel_addr     <= '0;
      pixel_write    <= 1'b0;
      frame_complete <= 1'b0;
      write_buffer   <= 1'b0;
    end else begin
      pixel_write    <= 1'b0;
      frame_complete <= 1'b0;

      // Flip halves one cycle after the final write, so that write still
      // lands in the half it belongs to.
      if (frame_complete) begin
        write_buffer <= ~write_buffer;
      end

      if (spi_rise) begin
        shift_reg <= assembled[PIXEL_BITS-2:0];
        if (bit_cnt == LAST_BIT) begin
          // Counter is back at 0 while the strobe is high, so an edge in
          // the write cycle starts the next word without losing a bit.
          bit_cnt        <= '0;
          pixel_write    <= 1'b1;
          pixel_data     <= assembled;
          pixel_addr     <= pix_cnt;
          frame_complete <= (pix_cnt == LAST_ADDR);
          pix_cnt        <= (pix_cnt == LAST_ADDR) ? '0 : pix_cnt + 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (resync) begin
        bit_cnt <= '0;
        pix_cnt <= '0;
      end
    end
  end

endmodule
